// File: rtl/noc_vc_inject_port_if.sv
// noc_vc_inject_port_if: source-side flit handshake and network-side flit/credit bundle
interface noc_vc_inject_port_if #(
  parameter int NUM_VC      = 4,
  parameter int DATA_W      = 32,
  parameter int NET_CREDITS = 4
);
  localparam int VC_W   = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
  localparam int CRED_W = $clog2(NET_CREDITS + 1);
  logic                     in_valid;
  logic [VC_W-1:0]          in_vc;
  logic                     in_tail;
  logic [DATA_W-1:0]        in_data;
  logic                     in_ready;
  logic                     flit_out_en;
  logic [DATA_W+VC_W+1:0]   flit_out;
  logic                     credit_in_en;
  logic [VC_W-1:0]          credit_in_vc;
  logic [NUM_VC*CRED_W-1:0] credits_avail;
  logic                     cred_err;
  logic [31:0]              flit_count;
  modport master (
    output in_valid, in_vc, in_tail, in_data, credit_in_en, credit_in_vc,
    input  in_ready, flit_out_en, flit_out, credits_avail, cred_err, flit_count
  );
  modport slave (
    input  in_valid, in_vc, in_tail, in_data, credit_in_en, credit_in_vc,
    output in_ready, flit_out_en, flit_out, credits_avail, cred_err, flit_count
  );
endinterface

// File: rtl/noc_vc_inject_port.sv
// noc_vc_inject_port: per-VC queues and credit counters feeding one network port through a round-robin arbiter
module noc_vc_inject_port #(
  parameter int NUM_VC      = 4,
  parameter int DATA_W      = 32,
  parameter int Q_DEPTH     = 4,
  parameter int NET_CREDITS = 4,
  parameter bit PKT_LOCK    = 1'b0
) (
  input logic Clk,
  input logic Rst,
  noc_vc_inject_port_if.slave bus
);
  localparam int VC_W   = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
  localparam int CRED_W = $clog2(NET_CREDITS + 1);
  localparam int QA_W   = $clog2(Q_DEPTH);
  logic [DATA_W:0]        r_mem [NUM_VC][Q_DEPTH];
  logic [QA_W-1:0]        r_wp [NUM_VC];
  logic [QA_W-1:0]        r_rp [NUM_VC];
  logic [QA_W:0]          r_cnt [NUM_VC];
  logic [CRED_W-1:0]      r_cred [NUM_VC];
  logic [VC_W-1:0]        r_ptr;
  logic [VC_W-1:0]        r_lock_vc;
  logic                   r_locked;
  logic                   r_en;
  logic                   r_err;
  logic [DATA_W+VC_W+1:0] r_flit;
  logic [31:0]            r_count;
  logic [NUM_VC-1:0]      w_elig;
  logic [NUM_VC-1:0]      w_pop;
  logic [NUM_VC-1:0]      w_put;
  logic [NUM_VC-1:0]      w_ret;
  logic                   w_push;
  logic                   w_issue;
  logic [VC_W-1:0]        w_win;
  logic [VC_W-1:0]        w_cand;
  logic [DATA_W:0]        w_head;
  assign bus.in_ready = (32'(bus.in_vc) < NUM_VC) && (r_cnt[bus.in_vc] != (QA_W+1)'(Q_DEPTH));
  assign w_push       = bus.in_valid && bus.in_ready;
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign w_elig[v] = r_cnt[v] != '0 && r_cred[v] != '0 && (!r_locked || r_lock_vc == VC_W'(v));
    assign w_pop[v]  = w_issue && w_win == VC_W'(v);
    assign w_put[v]  = w_push && bus.in_vc == VC_W'(v);
    assign w_ret[v]  = bus.credit_in_en && bus.credit_in_vc == VC_W'(v);
    assign bus.credits_avail[v*CRED_W +: CRED_W] = r_cred[v];
  end
  // Search starts one past the last winner so every VC gets a turn.
  always_comb begin
    w_issue = 1'b0;
    w_win   = r_ptr;
    w_cand  = r_ptr;
    for (int i = 1; i <= NUM_VC; i++) begin
      w_cand = VC_W'((int'(r_ptr) + i) % NUM_VC);
      if (!w_issue && w_elig[w_cand]) begin
        w_issue = 1'b1;
        w_win   = w_cand;
      end
    end
  end
  assign w_head = r_mem[w_win][r_rp[w_win]];
  always_ff @(posedge Clk)
    if (w_push) r_mem[bus.in_vc][r_wp[bus.in_vc]] <= {bus.in_tail, bus.in_data};
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_wp[v]   <= '0;
        r_rp[v]   <= '0;
        r_cnt[v]  <= '0;
        r_cred[v] <= CRED_W'(NET_CREDITS);
      end
      r_ptr     <= VC_W'(NUM_VC - 1);
      r_locked  <= 1'b0;
      r_lock_vc <= '0;
      r_en      <= 1'b0;
      r_flit    <= '0;
      r_err     <= 1'b0;
      r_count   <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_put[v]) r_wp[v] <= r_wp[v] + 1'b1;
        if (w_pop[v]) r_rp[v] <= r_rp[v] + 1'b1;
        if (w_put[v] != w_pop[v]) r_cnt[v] <= w_put[v] ? r_cnt[v] + 1'b1 : r_cnt[v] - 1'b1;
        if (w_ret[v] && !w_pop[v]) begin
          if (r_cred[v] == CRED_W'(NET_CREDITS)) r_err <= 1'b1;
          else r_cred[v] <= r_cred[v] + 1'b1;
        end else if (w_pop[v] && !w_ret[v]) r_cred[v] <= r_cred[v] - 1'b1;
      end
      r_en <= w_issue;
      if (w_issue) begin
        r_ptr   <= w_win;
        r_flit  <= {1'b1, w_head[DATA_W], w_win, w_head[DATA_W-1:0]};
        r_count <= r_count + 1'b1;
        if (PKT_LOCK) begin
          r_locked  <= !w_head[DATA_W];
          r_lock_vc <= w_win;
        end
      end else r_flit[DATA_W+VC_W+1] <= 1'b0;
    end
  end
  assign bus.flit_out_en = r_en;
  assign bus.flit_out    = r_flit;
  assign bus.cred_err    = r_err;
  assign bus.flit_count  = r_count;
endmodule

// File: tb/tb_noc_vc_inject_port.sv
// tb_noc_vc_inject_port: directed scenarios on unlocked, locked and default-parameter instances
module tb_noc_vc_inject_port;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_tail = 1'b0;
  logic        credit_in_en = 1'b0;
  logic [1:0]  in_vc = '0;
  logic [1:0]  credit_in_vc = '0;
  logic [31:0] in_data = '0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  noc_vc_inject_port_if #(.NUM_VC(4), .DATA_W(32), .NET_CREDITS(4)) b0 ();
  noc_vc_inject_port_if #(.NUM_VC(4), .DATA_W(32), .NET_CREDITS(4)) b1 ();
  noc_vc_inject_port_if #(.NUM_VC(4), .DATA_W(32), .NET_CREDITS(4)) bd ();
  assign b0.in_valid = in_valid;
  assign b0.in_vc = in_vc;
  assign b0.in_tail = in_tail;
  assign b0.in_data = in_data;
  assign b0.credit_in_en = credit_in_en;
  assign b0.credit_in_vc = credit_in_vc;
  assign b1.in_valid = in_valid;
  assign b1.in_vc = in_vc;
  assign b1.in_tail = in_tail;
  assign b1.in_data = in_data;
  assign b1.credit_in_en = credit_in_en;
  assign b1.credit_in_vc = credit_in_vc;
  assign bd.in_valid = in_valid;
  assign bd.in_vc = in_vc;
  assign bd.in_tail = in_tail;
  assign bd.in_data = in_data;
  assign bd.credit_in_en = credit_in_en;
  assign bd.credit_in_vc = credit_in_vc;
  noc_vc_inject_port #(.NUM_VC(4), .DATA_W(32), .Q_DEPTH(8), .NET_CREDITS(4), .PKT_LOCK(1'b0)) dut0 (
    .Clk(clk), .Rst(rst), .bus(b0.slave));
  noc_vc_inject_port #(.NUM_VC(4), .DATA_W(32), .Q_DEPTH(8), .NET_CREDITS(4), .PKT_LOCK(1'b1)) dut1 (
    .Clk(clk), .Rst(rst), .bus(b1.slave));
  noc_vc_inject_port dutd (.Clk(clk), .Rst(rst), .bus(bd.slave));
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    credit_in_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic push(input logic [1:0] vc, input logic t, input logic [31:0] d);
    in_valid = 1'b1;
    in_vc = vc;
    in_tail = t;
    in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (bd.flit_out_en !== 1'b0) begin errors++; $display("FAIL reset_en got %0b exp 0", bd.flit_out_en); end
    checks++; if (bd.flit_out !== 36'h0) begin errors++; $display("FAIL reset_flit got %h exp 0", bd.flit_out); end
    checks++; if (bd.credits_avail !== 12'h924) begin errors++; $display("FAIL reset_cred got %h exp 924", bd.credits_avail); end
    checks++; if (b0.credits_avail !== 12'h924) begin errors++; $display("FAIL reset_cred0 got %h exp 924", b0.credits_avail); end
    checks++; if (bd.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", bd.in_ready); end
    checks++; if (bd.cred_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", bd.cred_err); end
    checks++; if (bd.flit_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bd.flit_count); end
  endtask
  task automatic test_single();
    do_reset();
    push(2'd0, 1'b1, 32'hA5);
    checks++; if (b0.flit_out_en !== 1'b0) begin errors++; $display("FAIL single_early got %0b exp 0", b0.flit_out_en); end
    @(negedge clk);
    checks++; if (b0.flit_out_en !== 1'b1) begin errors++; $display("FAIL single_en got %0b exp 1", b0.flit_out_en); end
    checks++; if (b0.flit_out !== {1'b1, 1'b1, 2'd0, 32'hA5}) begin errors++; $display("FAIL single_flit got %h exp %h", b0.flit_out, {1'b1, 1'b1, 2'd0, 32'hA5}); end
    checks++; if (b0.credits_avail[2:0] !== 3'd3) begin errors++; $display("FAIL single_cred got %0d exp 3", b0.credits_avail[2:0]); end
    checks++; if (b0.flit_count !== 32'd1) begin errors++; $display("FAIL single_count got %0d exp 1", b0.flit_count); end
    @(negedge clk);
    checks++; if (b0.flit_out_en !== 1'b0) begin errors++; $display("FAIL single_off got %0b exp 0", b0.flit_out_en); end
    checks++; if (b0.flit_out !== {1'b0, 1'b1, 2'd0, 32'hA5}) begin errors++; $display("FAIL single_hold got %h exp %h", b0.flit_out, {1'b0, 1'b1, 2'd0, 32'hA5}); end
  endtask
  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 6; i++) push(2'd1, 1'b1, 32'h100 + i);
    repeat (3) @(negedge clk);
    checks++; if (b0.flit_count !== 32'd4) begin errors++; $display("FAIL bp_count got %0d exp 4", b0.flit_count); end
    checks++; if (b0.flit_out_en !== 1'b0) begin errors++; $display("FAIL bp_idle got %0b exp 0", b0.flit_out_en); end
    checks++; if (b0.credits_avail[5:3] !== 3'd0) begin errors++; $display("FAIL bp_cred got %0d exp 0", b0.credits_avail[5:3]); end
    credit_in_en = 1'b1;
    credit_in_vc = 2'd1;
    @(negedge clk);
    credit_in_en = 1'b0;
    checks++; if (b0.flit_out_en !== 1'b0) begin errors++; $display("FAIL bp_ret_early got %0b exp 0", b0.flit_out_en); end
    @(negedge clk);
    checks++; if (b0.flit_out !== {1'b1, 1'b1, 2'd1, 32'h104}) begin errors++; $display("FAIL bp_fifth got %h exp %h", b0.flit_out, {1'b1, 1'b1, 2'd1, 32'h104}); end
    checks++; if (b0.credits_avail[5:3] !== 3'd0) begin errors++; $display("FAIL bp_cred2 got %0d exp 0", b0.credits_avail[5:3]); end
    checks++; if (b0.flit_count !== 32'd5) begin errors++; $display("FAIL bp_count2 got %0d exp 5", b0.flit_count); end
    for (int i = 0; i < 7; i++) push(2'd1, 1'b1, 32'h200 + i);
    in_vc = 2'd1;
    #1;
    checks++; if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %0b exp 0", b0.in_ready); end
    in_vc = 2'd2;
    #1;
    checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL bp_other got %0b exp 1", b0.in_ready); end
  endtask
  task automatic test_rr();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push(2'(i % 3), 1'b1, 32'h10 + i);
      if (i > 0) begin
        checks++;
        if ({b0.flit_out_en, b0.flit_out[33:32]} !== {1'b1, 2'((i - 1) % 3)}) begin
          errors++; $display("FAIL rr_order%0d got en %0b vc %0d exp vc %0d", i, b0.flit_out_en, b0.flit_out[33:32], (i - 1) % 3);
        end
      end
    end
    @(negedge clk);
    checks++; if ({b0.flit_out_en, b0.flit_out[33:32]} !== 3'b110) begin errors++; $display("FAIL rr_last got en %0b vc %0d exp vc 2", b0.flit_out_en, b0.flit_out[33:32]); end
    @(negedge clk);
    checks++; if (b0.flit_count !== 32'd6) begin errors++; $display("FAIL rr_count got %0d exp 6", b0.flit_count); end
  endtask
  task automatic prep_lock();
    do_reset();
    for (int i = 0; i < 4; i++) push(2'd0, 1'b1, 32'h40 + i);
    push(2'd3, 1'b1, 32'h44);
    repeat (3) @(negedge clk);
    push(2'd0, 1'b0, 32'h50);
    push(2'd0, 1'b0, 32'h51);
    push(2'd0, 1'b1, 32'h52);
  endtask
  task automatic test_lock();
    logic [15:0] ord0 = '0, ord1 = '0;
    logic [7:0]  msk0 = '0, msk1 = '0;
    prep_lock();
    in_valid = 1'b1; in_vc = 2'd1; in_tail = 1'b1; in_data = 32'h60;
    credit_in_en = 1'b1; credit_in_vc = 2'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 2) credit_in_en = 1'b0;
      if (b0.flit_out_en) begin ord0 = {ord0[13:0], b0.flit_out[33:32]}; msk0[k] = 1'b1; end
      if (b1.flit_out_en) begin ord1 = {ord1[13:0], b1.flit_out[33:32]}; msk1[k] = 1'b1; end
    end
    checks++; if (ord0 !== 16'h0010) begin errors++; $display("FAIL unlocked_order got %h exp 0010", ord0); end
    checks++; if (msk0 !== 8'h1E) begin errors++; $display("FAIL unlocked_cycles got %h exp 1e", msk0); end
    checks++; if (ord1 !== 16'h0001) begin errors++; $display("FAIL locked_order got %h exp 0001", ord1); end
    checks++; if (msk1 !== 8'h1E) begin errors++; $display("FAIL locked_cycles got %h exp 1e", msk1); end
    checks++; if (b0.credits_avail !== 12'h718) begin errors++; $display("FAIL unlocked_cred got %h exp 718", b0.credits_avail); end
    checks++; if (b1.credits_avail !== 12'h718) begin errors++; $display("FAIL locked_cred got %h exp 718", b1.credits_avail); end
  endtask
  task automatic test_mid_reset();
    prep_lock();
    in_valid = 1'b1; in_vc = 2'd1; in_tail = 1'b1; in_data = 32'h60;
    credit_in_en = 1'b1; credit_in_vc = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (b1.flit_out !== {1'b1, 1'b0, 2'd0, 32'h50}) begin errors++; $display("FAIL mid_head got %h exp %h", b1.flit_out, {1'b1, 1'b0, 2'd0, 32'h50}); end
    rst = 1'b1; credit_in_en = 1'b0;
    in_valid = 1'b1; in_vc = 2'd1; in_tail = 1'b1; in_data = 32'h99;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (b1.flit_out !== 36'h0) begin errors++; $display("FAIL mid_flit got %h exp 0", b1.flit_out); end
    checks++; if (b1.credits_avail !== 12'h924) begin errors++; $display("FAIL mid_cred got %h exp 924", b1.credits_avail); end
    checks++; if (b1.flit_count !== 32'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", b1.flit_count); end
    push(2'd1, 1'b1, 32'h77);
    checks++; if (b1.flit_out_en !== 1'b0) begin errors++; $display("FAIL mid_ignored got %0b exp 0", b1.flit_out_en); end
    @(negedge clk);
    checks++; if (b1.flit_out !== {1'b1, 1'b1, 2'd1, 32'h77}) begin errors++; $display("FAIL mid_unlock got %h exp %h", b1.flit_out, {1'b1, 1'b1, 2'd1, 32'h77}); end
    @(negedge clk);
    checks++; if ({b1.flit_out_en, b1.flit_count} !== {1'b0, 32'd1}) begin errors++; $display("FAIL mid_empty got en %0b count %0d exp en 0 count 1", b1.flit_out_en, b1.flit_count); end
  endtask
  task automatic test_credit_err();
    do_reset();
    credit_in_en = 1'b1; credit_in_vc = 2'd2;
    @(negedge clk);
    credit_in_en = 1'b0;
    checks++; if (b0.credits_avail[8:6] !== 3'd4) begin errors++; $display("FAIL ovf_cred got %0d exp 4", b0.credits_avail[8:6]); end
    checks++; if (b0.cred_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %0b exp 1", b0.cred_err); end
    repeat (3) @(negedge clk);
    checks++; if (b0.cred_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", b0.cred_err); end
    push(2'd3, 1'b1, 32'h31);
    push(2'd3, 1'b1, 32'h32);
    repeat (2) @(negedge clk);
    checks++; if (b0.credits_avail[11:9] !== 3'd2) begin errors++; $display("FAIL same_pre got %0d exp 2", b0.credits_avail[11:9]); end
    push(2'd3, 1'b1, 32'h33);
    credit_in_en = 1'b1; credit_in_vc = 2'd3;
    @(negedge clk);
    credit_in_en = 1'b0;
    checks++; if (b0.flit_out !== {1'b1, 1'b1, 2'd3, 32'h33}) begin errors++; $display("FAIL same_issue got %h exp %h", b0.flit_out, {1'b1, 1'b1, 2'd3, 32'h33}); end
    checks++; if (b0.credits_avail[11:9] !== 3'd2) begin errors++; $display("FAIL same_cred got %0d exp 2", b0.credits_avail[11:9]); end
    @(negedge clk);
    checks++; if ({b0.cred_err, b0.credits_avail[11:9]} !== {1'b1, 3'd2}) begin errors++; $display("FAIL same_after got err %0b cred %0d exp err 1 cred 2", b0.cred_err, b0.credits_avail[11:9]); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_rr();
    test_lock();
    test_mid_reset();
    test_credit_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
